// File: rtl/inst_loader_pkg.sv
// ============================================================================
// Module   : inst_loader_pkg
// Purpose  : Shared state encoding and frame field widths for the IROM loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package inst_loader_pkg;

    localparam int c_LEN_W          = 16;
    localparam int c_BYTE_W         = 8;
    localparam int c_WORD_W         = 32;
    localparam int c_BYTES_PER_WORD = c_WORD_W / c_BYTE_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN0  = 3'd1,
        ST_LEN1  = 3'd2,
        ST_DATA  = 3'd3,
        ST_WRITE = 3'd4,
        ST_CSUM  = 3'd5,
        ST_DONE  = 3'd6,
        ST_ERR   = 3'd7
    } state_t;

endpackage

`default_nettype wire

// File: rtl/byte_packer.sv
// ============================================================================
// Module   : byte_packer
// Purpose  : Packs four little-endian bytes into one 32-bit instruction word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_packer
    import inst_loader_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                byte_valid,
    input  logic [c_BYTE_W-1:0] byte_data,
    output logic [c_WORD_W-1:0] word,
    output logic                word_valid
);

    // Holds the three earlier bytes; the 4th completes the word combinationally
    logic [c_WORD_W-c_BYTE_W-1:0] r_shift;
    logic [1:0]                   r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (clear) begin
            r_cnt   <= '0;
        end else if (byte_valid) begin
            r_shift <= {byte_data, r_shift[c_WORD_W-c_BYTE_W-1:c_BYTE_W]};
            r_cnt   <= r_cnt + 2'd1;
        end
    end

    assign word       = {byte_data, r_shift};
    assign word_valid = byte_valid && !clear && (r_cnt == 2'd3);

endmodule

`default_nettype wire

// File: rtl/inst_loader.sv
// ============================================================================
// Module   : inst_loader
// Purpose  : Boot loader: serial byte frame -> sequential IROM word writes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                rx_valid,
    input  logic [c_BYTE_W-1:0] rx_data,
    output logic                rx_ready,
    output logic                irom_we,
    output logic [ADDR_W-1:0]   irom_addr,
    output logic [c_WORD_W-1:0] irom_wdata,
    output logic                cpu_rst,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [ADDR_W:0]     word_cnt
);

    state_t                r_state;
    state_t                w_next;
    logic [c_LEN_W-1:0]    r_len;
    logic [c_BYTE_W-1:0]   r_csum;
    logic [ADDR_W:0]       r_word_cnt;
    logic [ADDR_W-1:0]     r_addr;
    logic [c_WORD_W-1:0]   r_wdata;
    logic                  r_done;
    logic                  r_err;

    logic                  w_fire;
    logic                  w_start_ok;
    logic                  w_data_fire;
    logic [c_LEN_W-1:0]    w_len_n;
    logic                  w_len_over;
    logic                  w_len_zero;
    logic                  w_last_word;
    logic                  w_pack_valid;
    logic [c_WORD_W-1:0]   w_pack_word;

    assign w_fire      = rx_valid && rx_ready;
    assign w_data_fire = w_fire && (r_state == ST_DATA);
    assign w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                   (r_state == ST_ERR));
    assign w_len_n     = {rx_data, r_len[c_BYTE_W-1:0]};
    // Exactly 2^ADDR_W words is a full IROM and still legal
    assign w_len_over  = 32'(w_len_n) > (32'd1 << ADDR_W);
    assign w_len_zero  = (w_len_n == '0);
    assign w_last_word = (32'(r_word_cnt) + 32'd1) == 32'(r_len);

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (w_start_ok),
        .byte_valid (w_data_fire),
        .byte_data  (rx_data),
        .word       (w_pack_word),
        .word_valid (w_pack_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        rx_ready = 1'b0;
        irom_we  = 1'b0;
        cpu_rst  = 1'b1;
        busy     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cpu_rst = 1'b0;
                if (start) w_next = ST_LEN0;
            end
            ST_LEN0: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (rx_valid) w_next = ST_LEN1;
            end
            ST_LEN1: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (rx_valid) begin
                    if (w_len_over)      w_next = ST_ERR;
                    else if (w_len_zero) w_next = ST_CSUM;
                    else                 w_next = ST_DATA;
                end
            end
            ST_DATA: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (w_pack_valid) w_next = ST_WRITE;
            end
            ST_WRITE: begin
                irom_we = 1'b1;
                busy    = 1'b1;
                w_next  = w_last_word ? ST_CSUM : ST_DATA;
            end
            ST_CSUM: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (rx_valid) w_next = (rx_data == r_csum) ? ST_DONE : ST_ERR;
            end
            ST_DONE: begin
                cpu_rst = 1'b0;
                if (start) w_next = ST_LEN0;
            end
            ST_ERR: begin
                if (start) w_next = ST_LEN0;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Write address/data are captured with the 4th byte so they are stable
    // throughout WRITE and then hold until the next word completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len      <= '0;
            r_csum     <= '0;
            r_word_cnt <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_csum     <= '0;
                r_word_cnt <= '0;
                r_done     <= 1'b0;
                r_err      <= 1'b0;
            end
            if (w_fire && (r_state == ST_LEN0)) begin
                r_len[c_BYTE_W-1:0] <= rx_data;
            end
            if (w_fire && (r_state == ST_LEN1)) begin
                r_len <= w_len_n;
                if (w_len_over) r_err <= 1'b1;
            end
            if (w_data_fire) begin
                r_csum <= r_csum ^ rx_data;
                if (w_pack_valid) begin
                    r_addr  <= r_word_cnt[ADDR_W-1:0];
                    r_wdata <= w_pack_word;
                end
            end
            if (r_state == ST_WRITE) begin
                r_word_cnt <= r_word_cnt + {{ADDR_W{1'b0}}, 1'b1};
            end
            if (w_fire && (r_state == ST_CSUM)) begin
                if (rx_data == r_csum) r_done <= 1'b1;
                else                   r_err  <= 1'b1;
            end
        end
    end

    assign irom_addr  = r_addr;
    assign irom_wdata = r_wdata;
    assign word_cnt   = r_word_cnt;
    assign done       = r_done;
    assign err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_inst_loader.sv
// ============================================================================
// Module   : tb_inst_loader
// Purpose  : Self-checking bench for inst_loader against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_loader;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk;
    logic              rst;
    logic              start;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              irom_we;
    logic [ADDR_W-1:0] irom_addr;
    logic [31:0]       irom_wdata;
    logic              cpu_rst;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   word_cnt;

    inst_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .irom_we    (irom_we),
        .irom_addr  (irom_addr),
        .irom_wdata (irom_wdata),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .word_cnt   (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0] cap_addr[$];
    logic [31:0]       cap_data[$];
    logic [31:0]       pay[$];

    always @(negedge clk) begin
        if (irom_we === 1'b1) begin
            cap_addr.push_back(irom_addr);
            cap_data.push_back(irom_wdata);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer one byte (after an optional idle gap) and return at the negedge
    // following the edge on which it transferred.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int tries;
        tries    = 0;
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        while (rx_ready !== 1'b1 && tries < 20) begin
            @(negedge clk);
            tries++;
        end
        if (tries >= 20) check_eq("rx_ready_wait", rx_ready, 1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_rx_ready"}, rx_ready, 0);
        check_eq({tag, "_irom_we"}, irom_we, 0);
        check_eq({tag, "_cpu_rst"}, cpu_rst, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_err"}, err, 0);
        check_eq({tag, "_addr"}, irom_addr, 0);
        check_eq({tag, "_wdata"}, irom_wdata, 0);
        check_eq({tag, "_word_cnt"}, word_cnt, 0);
    endtask

    // Sends a frame of n words taken from pay[] and checks the outcome
    // against the frame rules: in-order writes, XOR checksum, overflow.
    task automatic run_frame(input int n, input bit bad, input bit gapped,
                             input bit do_start, input bit mid_start);
        logic [7:0]  x;
        logic [7:0]  b;
        logic [15:0] len;
        bit          over;
        x    = 8'h00;
        len  = n[15:0];
        over = (n > DEPTH);
        cap_addr.delete();
        cap_data.delete();
        if (do_start) pulse_start();
        check_eq("busy_after_start", busy, 1);
        check_eq("cpu_rst_loading", cpu_rst, 1);
        check_eq("done_cleared", done, 0);
        check_eq("err_cleared", err, 0);
        send_byte(len[7:0], 0);
        send_byte(len[15:8], 0);
        if (over) begin
            check_eq("ovf_err", err, 1);
            check_eq("ovf_done", done, 0);
            check_eq("ovf_rx_ready", rx_ready, 0);
            check_eq("ovf_busy", busy, 0);
            check_eq("ovf_cpu_rst", cpu_rst, 1);
            check_eq("ovf_word_cnt", word_cnt, 0);
            check_eq("ovf_writes", cap_addr.size(), 0);
            return;
        end
        for (int i = 0; i < n; i++) begin
            if (mid_start && i == 0) begin
                pulse_start();
                check_eq("start_busy_ignored", busy, 1);
            end
            for (int k = 0; k < 4; k++) begin
                b = pay[i][8*k +: 8];
                x = x ^ b;
                send_byte(b, gapped ? 1 : 0);
            end
        end
        send_byte(bad ? (x ^ 8'h01) : x, 0);
        check_eq("end_done", done, !bad);
        check_eq("end_err", err, bad);
        check_eq("end_cpu_rst", cpu_rst, bad);
        check_eq("end_busy", busy, 0);
        check_eq("end_rx_ready", rx_ready, 0);
        check_eq("end_word_cnt", word_cnt, n);
        check_eq("n_writes", cap_addr.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < cap_addr.size()) begin
                check_eq("wr_addr", cap_addr[i], i);
                check_eq("wr_data", cap_data[i], pay[i]);
            end
        end
        if (n > 0) begin
            check_eq("hold_addr", irom_addr, n - 1);
            check_eq("hold_wdata", irom_wdata, pay[n-1]);
        end
    endtask

    task automatic fill_payload(input int n);
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back($urandom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst      = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        pay.delete();
        pay.push_back(32'h00100513);
        pay.push_back(32'h00A505B3);
        run_frame(2, 0, 0, 1, 0);
        run_frame(2, 1, 0, 1, 0);
        run_frame(0, 0, 0, 1, 0);
        run_frame(17, 0, 0, 1, 0);
        // restart after ERR, with backpressure and a start while busy
        run_frame(2, 0, 1, 1, 1);

        fill_payload(DEPTH);
        run_frame(DEPTH, 0, 0, 1, 0);

        // asynchronous reset in the middle of a load
        pulse_start();
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        send_byte(8'hAA, 0);
        #2 rst = 1'b1;
        #1 check_idle_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // start together with rx_valid in IDLE must not consume the byte
        start    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'hFF;
        @(negedge clk);
        start    = 1'b0;
        rx_valid = 1'b0;
        check_eq("start_rx_len0_ready", rx_ready, 1);
        fill_payload(1);
        run_frame(1, 0, 0, 0, 0);

        for (int t = 0; t < 12; t++) begin
            n = $urandom_range(0, DEPTH);
            if ($urandom_range(0, 5) == 0) n = $urandom_range(DEPTH + 1, 65535);
            fill_payload((n > DEPTH) ? 0 : n);
            run_frame(n, ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1, 1,
                      $urandom_range(0, 1) == 1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
